bus_arb4: RTL and testbench
===========================

BUS_ARB4 -- requirements
Module: bus_arb4

Interface
REQ-001 Parameter registerDataWidth, default from parameters.v (shared processor data width), width of all data ports.
REQ-002 Parameter TIMEOUT, default 15, max cycles a grant waits for out_ready before abort; legal range 1..255.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  request per requester, bit i = requester i.
REQ-006 data0..data3  input  registerDataWidth each  requester i payload, stable while req[i] high.
REQ-007 out_ready  input  1  consumer accepts out_data this cycle.
REQ-008 sel  output  2  registered mux selector, 2'b00..2'b11 = requester 0..3, same encoding as the processor 4:1 mux.
REQ-009 grant  output  4  one-hot current grant, all-zero when idle.
REQ-010 out_valid  output  1  out_data valid to consumer.
REQ-011 out_data  output  registerDataWidth  payload of granted requester (data[sel]).
REQ-012 ack  output  4  one-cycle pulse to requester i on completed transfer.
REQ-013 timeout_err  output  1  one-cycle pulse when a grant is aborted by timeout.

Function
REQ-014 FSM states IDLE and GRANT only; encoding free.
REQ-015 IDLE, req==0: stay IDLE, grant=0, out_valid=0.
REQ-016 IDLE, req!=0: next cycle enter GRANT, winner = first set req bit searching upward modulo 4 from (last+1), last = round-robin pointer.
REQ-017 sel and grant are registered on IDLE->GRANT transition and held constant for whole GRANT.
REQ-018 GRANT: out_valid=1, out_data=data[sel] combinationally from current inputs.
REQ-019 GRANT with out_ready=1: transfer completes that cycle; ack[sel] high for that cycle only; next cycle IDLE; last<=sel.
REQ-020 GRANT with out_ready=0: wait counter increments each cycle; counter cleared on entering GRANT.
REQ-021 Counter reaches TIMEOUT with out_ready=0: timeout_err pulses that cycle, no ack, return IDLE, last<=sel (aborted requester loses priority).
REQ-022 out_ready=1 on the same cycle counter reaches TIMEOUT: transfer wins, ack pulses, timeout_err stays 0.
REQ-023 Granted req bit dropping during GRANT: grant aborts next cycle to IDLE, no ack, no timeout_err, last<=sel.
REQ-024 Minimum one IDLE cycle between consecutive grants; max throughput one transfer per 2 cycles.
REQ-025 Fairness: with all four req held high, grants cycle 0,1,2,3,0,... with no requester skipped.
REQ-026 out_ready ignored in IDLE; ack and timeout_err never both high; at most one ack bit high.

Reset
REQ-027 rst high asynchronously forces IDLE, sel=2'b00, grant=4'b0000, out_valid=0, ack=4'b0000, timeout_err=0, counter=0, last=2'b11 (so requester 0 has first priority).
REQ-028 Reset asserted mid-GRANT drops grant immediately with no ack; first post-reset arbitration follows REQ-016 with last=3.

Verification
REQ-029 Reset, then req=4'b1111, out_ready=1 constant -> grants 0001,0010,0100,1000,0001 on every other cycle, sel 0,1,2,3,0, ack matches grant.
REQ-030 req=4'b0100, data2=0xA5, out_ready low 3 cycles then high -> out_valid high 4 cycles, out_data=0xA5, ack=4'b0100 single pulse on 4th GRANT cycle.
REQ-031 TIMEOUT=15, req=4'b0001, out_ready=0 -> timeout_err pulse on 15th wait cycle, IDLE next cycle, then req 0 regranted after one IDLE cycle with last=0 honoured.
REQ-032 last=1, req=4'b1001 -> requester 3 granted before 0; then req=4'b0001 -> 0 granted.
REQ-033 Grant to requester 2 active, rst pulsed high -> outputs at reset values immediately, no ack; after release req=4'b0110 -> requester 1 granted first.
REQ-034 GRANT to 1, req[1] dropped with out_ready=0 -> IDLE next cycle, no ack, no timeout_err.

Source files
------------

// File: rtl/bus_arb4.sv
// Four-way round-robin bus arbiter. A grant lasts until the consumer accepts,
// the granted requester withdraws, or the wait counter times out.
module bus_arb4 #(
  parameter int registerDataWidth = 32,
  parameter int TIMEOUT           = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   req,
  input  logic [registerDataWidth-1:0] data0,
  input  logic [registerDataWidth-1:0] data1,
  input  logic [registerDataWidth-1:0] data2,
  input  logic [registerDataWidth-1:0] data3,
  input  logic                         out_ready,
  output logic [1:0]                   sel,
  output logic [3:0]                   grant,
  output logic                         out_valid,
  output logic [registerDataWidth-1:0] out_data,
  output logic [3:0]                   ack,
  output logic                         timeout_err
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  // Abort fires on the TIMEOUT-th wait cycle; the counter is 0 on the first.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [3:0] grant_q, grant_d;
  logic [7:0] cnt_q, cnt_d;

  logic [1:0] pick, idx;
  logic       found;
  logic       in_grant, req_held, xfer, tmo, drop;
  logic [registerDataWidth-1:0] mux_data;

  // Search upward from the requester after the last one served.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign in_grant = (state_q == S_GRANT);
  assign req_held = req[sel_q];
  assign xfer     = in_grant && req_held && out_ready;
  assign tmo      = in_grant && req_held && !out_ready && (cnt_q == CNT_LAST);
  assign drop     = in_grant && !req_held;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          sel_d   = pick;
          grant_d = 4'b0001 << pick;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        if (xfer || tmo || drop) begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
          last_d  = sel_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      grant_q <= 4'b0000;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    mux_data = data0;
      2'd1:    mux_data = data1;
      2'd2:    mux_data = data2;
      default: mux_data = data3;
    endcase
  end

  assign sel         = sel_q;
  assign grant       = grant_q;
  assign out_valid   = in_grant;
  assign out_data    = in_grant ? mux_data : '0;
  assign ack         = xfer ? grant_q : 4'b0000;
  assign timeout_err = tmo;

endmodule

// File: tb/tb_bus_arb4.sv
// Directed-vector bench for bus_arb4 with hand-computed expectations.
module tb_bus_arb4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] data0, data1, data2, data3;
  logic         out_ready;
  logic [1:0]   sel;
  logic [3:0]   grant;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [3:0]   ack;
  logic         timeout_err;

  int n_tot = 0;
  int n_bad = 0;

  bus_arb4 #(.registerDataWidth(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .out_ready(out_ready), .sel(sel), .grant(grant), .out_valid(out_valid),
    .out_data(out_data), .ack(ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks everything visible in a GRANT cycle.
  task automatic chk_grant(input string tag, input logic [1:0] s, input logic [3:0] a,
                           input logic t);
    #1;
    chk({tag, ".grant"}, 32'(grant), 32'(4'b0001 << s));
    chk({tag, ".sel"}, 32'(sel), 32'(s));
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".ack"}, 32'(ack), 32'(a));
    chk({tag, ".tmo"}, 32'(timeout_err), 32'(t));
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, ".grant"}, 32'(grant), 32'd0);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".ack"}, 32'(ack), 32'd0);
    chk({tag, ".tmo"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
    data0 = 32'h1111_0000; data1 = 32'h2222_0001;
    data2 = 32'h0000_00A5; data3 = 32'h4444_0003;
    #3;
    chk("rst.sel", 32'(sel), 32'd0);
    chk_idle("rst");
    @(posedge clk); #2;
    rst = 1'b0;

    // Fairness: all requesting, consumer always ready.
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_grant($sformatf("rr%0d", i), 2'(i % 4), 4'b0001 << (i % 4), 1'b0);
      tick();
      chk_idle($sformatf("rr%0d.gap", i));
    end
    req = 4'b0000; out_ready = 1'b0;

    // Consumer stalls three cycles on requester 2.
    req = 4'b0100;
    tick();
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      out_ready = (i == 4);
      chk_grant($sformatf("stall%0d", i), 2'd2, (i == 4) ? 4'b0100 : 4'b0000, 1'b0);
      chk("stall.data", out_data, 32'h0000_00A5);
    end
    req = 4'b0000; out_ready = 1'b0;
    tick();
    chk_idle("stall.end");

    // Timeout on requester 0, then regrant after one idle cycle.
    req = 4'b0001;
    tick();
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) tick();
      #1;
      chk($sformatf("tmo%0d", k), 32'(timeout_err), 32'(k == 15));
      chk($sformatf("tmo%0d.ack", k), 32'(ack), 32'd0);
    end
    tick();
    chk_idle("tmo.idle");
    tick();
    out_ready = 1'b1;
    chk_grant("tmo.regrant", 2'd0, 4'b0001, 1'b0);

    // last=1 then req 1001: requester 3 ahead of 0.
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    chk_grant("p1", 2'd1, 4'b0010, 1'b0);
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    chk_grant("p3", 2'd3, 4'b1000, 1'b0);
    tick();
    req = 4'b0001;
    tick();
    chk_grant("p0", 2'd0, 4'b0001, 1'b0);
    req = 4'b0000;
    tick();

    // Reset in the middle of a grant to requester 2.
    req = 4'b0100; out_ready = 1'b0;
    tick();
    chk_grant("mid", 2'd2, 4'b0000, 1'b0);
    rst = 1'b1; out_ready = 1'b1;
    #1;
    chk("mid.rst.sel", 32'(sel), 32'd0);
    chk_idle("mid.rst");
    @(posedge clk); #2;
    rst = 1'b0; req = 4'b0110; out_ready = 1'b0;
    tick();
    chk_grant("post.rst", 2'd1, 4'b0000, 1'b0);

    // Requester 1 withdraws while stalled.
    req = 4'b0100;
    chk_grant("drop", 2'd1, 4'b0000, 1'b0);
    tick();
    chk_idle("drop.idle");
    tick();
    out_ready = 1'b1;
    chk_grant("drop.next", 2'd2, 4'b0100, 1'b0);

    // Ready arrives on the cycle the counter expires: transfer wins.
    req = 4'b0000;
    tick();
    req = 4'b0001; out_ready = 1'b0;
    tick();
    for (int k = 2; k <= 15; k++) tick();
    out_ready = 1'b1;
    chk_grant("race", 2'd0, 4'b0001, 1'b0);
    req = 4'b0000;
    tick();
    chk_idle("race.idle");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
